// File: rtl/datapath_seq_pkg.sv
// Shared types and constants for the Lab 5 datapath sequencer.
//   cmd_kind_t  : command kinds (MOVI, MOV, ALU, CMP)
//   seq_state_t : sequencer states (IDLE, RDA, RDB, EXEC, WRC, WRI)
//   cmd_t       : captured command payload
//   ctrl_t      : registered control bundle presented to the datapath
//   decode_ctrl : per-state control decode
package datapath_seq_pkg;

   localparam int unsigned KIND_W  = 2;
   localparam int unsigned REG_W   = 3;
   localparam int unsigned SHIFT_W = 2;
   localparam int unsigned ALUOP_W = 2;
   localparam int unsigned IMM_W   = 8;
   localparam int unsigned DATA_W  = 16;

   typedef enum logic [KIND_W-1:0] {
      MOVI = 2'b00,
      MOV  = 2'b01,
      ALU  = 2'b10,
      CMP  = 2'b11
   } cmd_kind_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RDA  = 3'd1,
      RDB  = 3'd2,
      EXEC = 3'd3,
      WRC  = 3'd4,
      WRI  = 3'd5
   } seq_state_t;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
   localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
   localparam logic [ALUOP_W-1:0] ALU_NOT = 2'b11;

   typedef struct packed {
      cmd_kind_t           kind;
      logic [REG_W-1:0]    rd;
      logic [REG_W-1:0]    rn;
      logic [REG_W-1:0]    rm;
      logic [SHIFT_W-1:0]  shift;
      logic [ALUOP_W-1:0]  aluop;
      logic [IMM_W-1:0]    imm;
   } cmd_t;

   // cmd_ready is kept as the MSB so the reset constant is easy to form
   typedef struct packed {
      logic                cmd_ready;
      logic [REG_W-1:0]    readnum;
      logic                loada;
      logic                loadb;
      logic [SHIFT_W-1:0]  shift;
      logic                asel;
      logic                bsel;
      logic [ALUOP_W-1:0]  alu_op;
      logic                loadc;
      logic                loads;
      logic [REG_W-1:0]    writenum;
      logic                write;
      logic                vsel;
      logic [DATA_W-1:0]   datapath_in;
      logic                done;
   } ctrl_t;

   // Control outputs for a given state and captured command; unlisted fields stay 0
   function automatic ctrl_t decode_ctrl(input seq_state_t st, input cmd_t c);
      ctrl_t o;
      o = '0;
      case (st)
         IDLE: o.cmd_ready = 1'b1;
         RDA: begin
            o.readnum = c.rn;
            o.loada   = 1'b1;
         end
         RDB: begin
            o.readnum = c.rm;
            o.loadb   = 1'b1;
         end
         EXEC: begin
            o.shift = c.shift;
            o.bsel  = 1'b0;
            o.loadc = 1'b1;
            case (c.kind)
               ALU: begin
                  o.asel   = 1'b0;
                  o.alu_op = c.aluop;
                  o.loads  = 1'b1;
               end
               CMP: begin
                  // compare only updates status; C keeps its value
                  o.asel   = 1'b0;
                  o.alu_op = ALU_SUB;
                  o.loads  = 1'b1;
                  o.loadc  = 1'b0;
                  o.done   = 1'b1;
               end
               default: begin
                  // MOV: zero A so the ALU passes the shifted B through
                  o.asel   = 1'b1;
                  o.alu_op = ALU_ADD;
                  o.loads  = 1'b0;
               end
            endcase
         end
         WRC: begin
            o.writenum = c.rd;
            o.write    = 1'b1;
            o.vsel     = 1'b0;
            o.done     = 1'b1;
         end
         WRI: begin
            o.writenum    = c.rd;
            o.write       = 1'b1;
            o.vsel        = 1'b1;
            o.datapath_in = DATA_W'(c.imm);
            o.done        = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Command handshake bundle between a command source and the sequencer.
//   master : command source (drives cmd_valid and fields, reads cmd_ready)
//   slave  : sequencer (reads cmd_valid and fields, drives cmd_ready)
interface datapath_sequencer_if;
   import datapath_seq_pkg::*;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [KIND_W-1:0]   cmd_kind;
   logic [REG_W-1:0]    cmd_rd;
   logic [REG_W-1:0]    cmd_rn;
   logic [REG_W-1:0]    cmd_rm;
   logic [SHIFT_W-1:0]  cmd_shift;
   logic [ALUOP_W-1:0]  cmd_aluop;
   logic [IMM_W-1:0]    cmd_imm;

   modport master (
      output cmd_valid, cmd_kind, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_aluop, cmd_imm,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_kind, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_aluop, cmd_imm,
      output cmd_ready
   );

endinterface

// File: rtl/datapath_sequencer.sv
// Automatic controller for the Lab 5 datapath: accepts one command per
// valid/ready handshake and steps the datapath through read, execute and
// writeback, pulsing done on the last action cycle.
//   clk, reset_n          : clock, asynchronous active-low reset
//   cmd                   : command handshake (slave side)
//   readnum/loada/loadb   : register read stage
//   shift/asel/bsel/ALUop/loadc/loads : execute stage
//   writenum/write/vsel/datapath_in   : writeback stage
//   done                  : last action cycle of a command
module datapath_sequencer
   import datapath_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   datapath_sequencer_if.slave  cmd,
   output logic [REG_W-1:0]     readnum,
   output logic                 loada,
   output logic                 loadb,
   output logic [SHIFT_W-1:0]   shift,
   output logic                 asel,
   output logic                 bsel,
   output logic [ALUOP_W-1:0]   ALUop,
   output logic                 loadc,
   output logic                 loads,
   output logic [REG_W-1:0]     writenum,
   output logic                 write,
   output logic                 vsel,
   output logic [DATA_W-1:0]    datapath_in,
   output logic                 done
);

   localparam int unsigned CTRL_W = $bits(ctrl_t);
   localparam ctrl_t CTRL_RESET = ctrl_t'({1'b1, (CTRL_W-1)'(0)});

   seq_state_t state_q, state_d;
   cmd_t       cmd_q, cmd_d, cmd_in;
   ctrl_t      ctrl_q, ctrl_d;

   // State, command and control registers; controls are registered from the
   // next state so every output is a clean Moore output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         ctrl_q  <= CTRL_RESET;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Next state, command capture and control decode
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;

      cmd_in.kind  = cmd_kind_t'(cmd.cmd_kind);
      cmd_in.rd    = cmd.cmd_rd;
      cmd_in.rn    = cmd.cmd_rn;
      cmd_in.rm    = cmd.cmd_rm;
      cmd_in.shift = cmd.cmd_shift;
      cmd_in.aluop = cmd.cmd_aluop;
      cmd_in.imm   = cmd.cmd_imm;

      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid) begin
               cmd_d = cmd_in;
               case (cmd_in.kind)
                  MOVI:    state_d = WRI;
                  MOV:     state_d = RDB;
                  default: state_d = RDA;
               endcase
            end
         end
         RDA:     state_d = RDB;
         RDB:     state_d = EXEC;
         EXEC:    state_d = (cmd_q.kind == CMP) ? IDLE : WRC;
         WRC:     state_d = IDLE;
         WRI:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ctrl_d = decode_ctrl(state_d, cmd_d);
   end

   assign cmd.cmd_ready = ctrl_q.cmd_ready;
   assign readnum       = ctrl_q.readnum;
   assign loada         = ctrl_q.loada;
   assign loadb         = ctrl_q.loadb;
   assign shift         = ctrl_q.shift;
   assign asel          = ctrl_q.asel;
   assign bsel          = ctrl_q.bsel;
   assign ALUop         = ctrl_q.alu_op;
   assign loadc         = ctrl_q.loadc;
   assign loads         = ctrl_q.loads;
   assign writenum      = ctrl_q.writenum;
   assign write         = ctrl_q.write;
   assign vsel          = ctrl_q.vsel;
   assign datapath_in   = ctrl_q.datapath_in;
   assign done          = ctrl_q.done;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer driving a behavioural Lab 5 datapath.
module tb_datapath_sequencer;
   import datapath_seq_pkg::*;

   logic clk;
   logic reset_n;

   datapath_sequencer_if bus();

   logic [2:0]  readnum, writenum;
   logic        loada, loadb, asel, bsel, loadc, loads, write, vsel, done;
   logic [1:0]  shift, ALUop;
   logic [15:0] datapath_in;

   int checks   = 0;
   int failures = 0;

   datapath_sequencer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd         (bus),
      .readnum     (readnum),
      .loada       (loada),
      .loadb       (loadb),
      .shift       (shift),
      .asel        (asel),
      .bsel        (bsel),
      .ALUop       (ALUop),
      .loadc       (loadc),
      .loads       (loads),
      .writenum    (writenum),
      .write       (write),
      .vsel        (vsel),
      .datapath_in (datapath_in),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lab 5 datapath model: register file, A/B/C registers, shifter, ALU, Z status
   logic [15:0] rf [8];
   logic [15:0] a_q, b_q, c_q, sout, ain, bin, alu_out;
   logic        z_q;
   logic [15:0] datapath_out;
   logic        Z_out;

   always_comb begin
      case (shift)
         2'b00:   sout = b_q;
         2'b01:   sout = {b_q[14:0], 1'b0};
         2'b10:   sout = {1'b0, b_q[15:1]};
         default: sout = {b_q[15], b_q[15:1]};
      endcase
      ain = asel ? 16'h0000 : a_q;
      bin = bsel ? {11'h000, datapath_in[4:0]} : sout;
      case (ALUop)
         2'b00:   alu_out = ain + bin;
         2'b01:   alu_out = ain - bin;
         2'b10:   alu_out = ain & bin;
         default: alu_out = ~bin;
      endcase
   end

   always_ff @(posedge clk) begin
      if (write) rf[writenum] <= vsel ? datapath_in : c_q;
      if (loada) a_q <= rf[readnum];
      if (loadb) b_q <= rf[readnum];
      if (loadc) c_q <= alu_out;
      if (loads) z_q <= (alu_out == 16'h0000);
   end

   assign datapath_out = c_q;
   assign Z_out        = z_q;

   // Field order: readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads,
   // writenum, write, vsel, datapath_in, done
   logic [34:0] all_out;
   assign all_out = {readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads,
                     writenum, write, vsel, datapath_in, done};

   function automatic logic [34:0] ov(input int rn, la, lb, sh, as, bs, op, lc, ls,
                                      wn, wr, vs, din, dn);
      return {3'(rn), 1'(la), 1'(lb), 2'(sh), 1'(as), 1'(bs), 2'(op), 1'(lc), 1'(ls),
              3'(wn), 1'(wr), 1'(vs), 16'(din), 1'(dn)};
   endfunction

   task automatic drive_cmd(input int k, rd, rn, rm, sh, op, imm);
      bus.cmd_kind  = 2'(k);
      bus.cmd_rd    = 3'(rd);
      bus.cmd_rn    = 3'(rn);
      bus.cmd_rm    = 3'(rm);
      bus.cmd_shift = 2'(sh);
      bus.cmd_aluop = 2'(op);
      bus.cmd_imm   = 8'(imm);
   endtask

   task automatic test_reset();
      reset_n       = 1'b1;
      bus.cmd_valid = 1'b0;
      drive_cmd(0, 0, 0, 0, 0, 0, 0);
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
      end
      checks++;
      if (all_out !== 35'h0) begin
         failures++; $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
         failures++; $display("FAIL post_reset_idle: ready %b outputs %h expected 1 / 0", bus.cmd_ready, all_out);
      end
   endtask

   task automatic test_movi_mov();
      drive_cmd(0, 3, 0, 0, 0, 0, 8'h2A);
      bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0;
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,0,0,0,3,1,1,16'h002A,1)) begin
         failures++; $display("FAIL movi_wri: got %h expected %h", all_out, ov(0,0,0,0,0,0,0,0,0,3,1,1,16'h002A,1));
      end
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
         failures++; $display("FAIL movi_busy_ready: got %b expected 0", bus.cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
         failures++; $display("FAIL movi_return_idle: ready %b outputs %h expected 1 / 0", bus.cmd_ready, all_out);
      end
      drive_cmd(1, 0, 0, 3, 0, 0, 0);
      bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0;
      checks++;
      if (all_out !== ov(3,0,1,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL mov_rdb: got %h expected %h", all_out, ov(3,0,1,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,1,0,0,1,0,0,0,0,0,0)) begin
         failures++; $display("FAIL mov_exec: got %h expected %h", all_out, ov(0,0,0,0,1,0,0,1,0,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,0,0,0,0,1,0,0,1)) begin
         failures++; $display("FAIL mov_wrc: got %h expected %h", all_out, ov(0,0,0,0,0,0,0,0,0,0,1,0,0,1));
      end
      checks++;
      if (datapath_out !== 16'h002A) begin
         failures++; $display("FAIL mov_datapath_out: got %h expected 002a", datapath_out);
      end
      @(negedge clk);
      checks++;
      if (rf[0] !== 16'h002A || bus.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL mov_r0: got %h ready %b expected 002a / 1", rf[0], bus.cmd_ready);
      end
   endtask

   task automatic test_alu_add_shift();
      drive_cmd(0, 1, 0, 0, 0, 0, 7);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0; @(negedge clk);
      drive_cmd(0, 2, 0, 0, 0, 0, 5);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0; @(negedge clk);
      drive_cmd(2, 4, 1, 2, 1, 0, 0);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0;
      checks++;
      if (all_out !== ov(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL alu_rda: got %h expected %h", all_out, ov(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(2,0,1,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL alu_rdb: got %h expected %h", all_out, ov(2,0,1,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,1,0,0,0,1,1,0,0,0,0,0)) begin
         failures++; $display("FAIL alu_exec: got %h expected %h", all_out, ov(0,0,0,1,0,0,0,1,1,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,0,0,0,4,1,0,0,1)) begin
         failures++; $display("FAIL alu_wrc: got %h expected %h", all_out, ov(0,0,0,0,0,0,0,0,0,4,1,0,0,1));
      end
      checks++;
      if (datapath_out !== 16'h0011 || Z_out !== 1'b0) begin
         failures++; $display("FAIL alu_result: got %h Z %b expected 0011 Z 0", datapath_out, Z_out);
      end
      @(negedge clk);
      checks++;
      if (rf[4] !== 16'h0011 || bus.cmd_ready !== 1'b1) begin
         failures++; $display("FAIL alu_r4: got %h ready %b expected 0011 / 1", rf[4], bus.cmd_ready);
      end
   endtask

   task automatic test_cmp_equal();
      drive_cmd(0, 1, 0, 0, 0, 0, 9);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0; @(negedge clk);
      // aluop field set to AND to show it is ignored for CMP
      drive_cmd(3, 0, 1, 1, 0, 2, 0);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0;
      checks++;
      if (all_out !== ov(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL cmp_rda: got %h expected %h", all_out, ov(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL cmp_rdb: got %h expected %h", all_out, ov(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,1,0,1,0,0,0,0,1)) begin
         failures++; $display("FAIL cmp_exec: got %h expected %h", all_out, ov(0,0,0,0,0,0,1,0,1,0,0,0,0,1));
      end
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
         failures++; $display("FAIL cmp_return_idle: ready %b outputs %h expected 1 / 0", bus.cmd_ready, all_out);
      end
      checks++;
      if (Z_out !== 1'b1 || datapath_out !== 16'h0011) begin
         failures++; $display("FAIL cmp_status: Z %b C %h expected Z 1 C 0011", Z_out, datapath_out);
      end
   endtask

   task automatic test_handshake();
      bus.cmd_valid = 1'b0;
      drive_cmd(2, 7, 5, 6, 3, 3, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
            failures++; $display("FAIL idle_no_valid: cycle %0d ready %b outputs %h expected 1 / 0", i, bus.cmd_ready, all_out);
         end
      end
      // ALU AND with valid held high and fields changing underneath
      drive_cmd(2, 5, 1, 2, 0, 2, 0);  bus.cmd_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (all_out !== ov(1,1,0,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL hold_rda: got %h expected %h", all_out, ov(1,1,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      drive_cmd(3, 6, 6, 7, 3, 3, 8'hFF);
      @(negedge clk);
      checks++;
      if (all_out !== ov(2,0,1,0,0,0,0,0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL hold_rdb: got %h expected %h", all_out, ov(2,0,1,0,0,0,0,0,0,0,0,0,0,0));
      end
      drive_cmd(1, 4, 0, 0, 1, 1, 8'h11);
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,2,1,1,0,0,0,0,0)) begin
         failures++; $display("FAIL hold_exec: got %h expected %h", all_out, ov(0,0,0,0,0,0,2,1,1,0,0,0,0,0));
      end
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,0,0,0,5,1,0,0,1)) begin
         failures++; $display("FAIL hold_wrc: got %h expected %h", all_out, ov(0,0,0,0,0,0,0,0,0,5,1,0,0,1));
      end
      drive_cmd(0, 7, 0, 0, 0, 0, 8'h5A);
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
         failures++; $display("FAIL hold_idle_gap: ready %b outputs %h expected 1 / 0", bus.cmd_ready, all_out);
      end
      @(negedge clk); bus.cmd_valid = 1'b0;
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,0,0,0,7,1,1,16'h005A,1)) begin
         failures++; $display("FAIL hold_next_accept: got %h expected %h", all_out, ov(0,0,0,0,0,0,0,0,0,7,1,1,16'h005A,1));
      end
      @(negedge clk);
      checks++;
      if (rf[5] !== 16'h0001 || rf[7] !== 16'h005A) begin
         failures++; $display("FAIL hold_results: R5 %h R7 %h expected 0001 / 005a", rf[5], rf[7]);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] ready_seq;
      logic [10:0] done_seq;
      int          done_cnt;
      ready_seq = '0;
      done_seq  = '0;
      done_cnt  = 0;
      drive_cmd(0, 2, 0, 0, 0, 0, 8'h0C);
      bus.cmd_valid = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         ready_seq[i-1] = bus.cmd_ready;
         done_seq[i-1]  = done;
         if (done) done_cnt++;
         if (i == 1) drive_cmd(1, 3, 0, 2, 0, 0, 0);
         if (i == 3) drive_cmd(2, 7, 2, 3, 0, 0, 0);
         if (i == 7) bus.cmd_valid = 1'b0;
      end
      checks++;
      if (ready_seq !== 11'h422) begin
         failures++; $display("FAIL b2b_ready_pattern: got %h expected 422", ready_seq);
      end
      checks++;
      if (done_seq !== 11'h211 || done_cnt != 3) begin
         failures++; $display("FAIL b2b_done_pulses: pattern %h count %0d expected 211 / 3", done_seq, done_cnt);
      end
      checks++;
      if (rf[7] !== 16'h0018 || datapath_out !== 16'h0018) begin
         failures++; $display("FAIL b2b_result: R7 %h C %h expected 0018", rf[7], datapath_out);
      end
   endtask

   task automatic test_reset_mid();
      drive_cmd(0, 6, 0, 0, 0, 0, 8'h33);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0; @(negedge clk);
      drive_cmd(2, 6, 1, 2, 0, 0, 0);  bus.cmd_valid = 1'b1;
      @(negedge clk); bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (all_out !== ov(0,0,0,0,0,0,0,1,1,0,0,0,0,0)) begin
         failures++; $display("FAIL rst_mid_exec: got %h expected %h", all_out, ov(0,0,0,0,0,0,0,1,1,0,0,0,0,0));
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
         failures++; $display("FAIL rst_mid_async: ready %b outputs %h expected 1 / 0", bus.cmd_ready, all_out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || all_out !== 35'h0) begin
         failures++; $display("FAIL rst_mid_no_wrc: ready %b outputs %h expected 1 / 0", bus.cmd_ready, all_out);
      end
      checks++;
      if (rf[6] !== 16'h0033) begin
         failures++; $display("FAIL rst_mid_dest_kept: got %h expected 0033", rf[6]);
      end
   endtask

   initial begin
      test_reset();
      test_movi_mov();
      test_alu_add_shift();
      test_cmp_equal();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
